// File: rtl/exe_pkg.sv
//------------------------------------------------------------------------------
// exe_pkg: op codes, mul/div FSM states and forwarding codes | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package exe_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_SLLV  = 5'd11;
  localparam logic [4:0] OP_SRLV  = 5'd12;
  localparam logic [4:0] OP_SRAV  = 5'd13;
  localparam logic [4:0] OP_LUI   = 5'd14;
  localparam logic [4:0] OP_MTHI  = 5'd15;
  localparam logic [4:0] OP_MTLO  = 5'd16;
  localparam logic [4:0] OP_MFHI  = 5'd17;
  localparam logic [4:0] OP_MFLO  = 5'd18;
  localparam logic [4:0] OP_MULT  = 5'd19;
  localparam logic [4:0] OP_MULTU = 5'd20;
  localparam logic [4:0] OP_DIV   = 5'd21;
  localparam logic [4:0] OP_DIVU  = 5'd22;

  localparam logic [1:0] FWD_RS  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/exe_muldiv.sv
//------------------------------------------------------------------------------
// exe_muldiv: multi-cycle multiplier and radix-2 restoring divider | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module exe_muldiv
  import exe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic              div_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, b_q, rem_q, quo_q, dvs_q;
  logic                sgn_q, div_q;

  logic [DATA_W-1:0]   abs_a, abs_b, rem_nxt, diff;
  logic [DATA_W:0]     shifted;
  logic                sub_ok;
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;
  logic                a_neg, b_neg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: if (start_i) begin
        state_d = div_i ? MD_DIV : MD_MUL;
        cnt_d   = '0;
      end
      MD_MUL: if (cnt_q == MUL_LAST) state_d = MD_DONE;
              else cnt_d = cnt_q + CNT_W'(1);
      MD_DIV: if (cnt_q == DIV_LAST) state_d = MD_DONE;
              else cnt_d = cnt_q + CNT_W'(1);
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) state_d = MD_IDLE;
  end

  assign busy_o = (state_q != MD_IDLE);
  assign done_o = (state_q == MD_DONE);

  // Divider runs on magnitudes; signs are reapplied when the result is read.
  assign abs_a   = (signed_i && a_i[DATA_W-1]) ? -a_i : a_i;
  assign abs_b   = (signed_i && b_i[DATA_W-1]) ? -b_i : b_i;
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign sub_ok  = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[DATA_W-1:0] - dvs_q;
  assign rem_nxt = sub_ok ? diff : shifted[DATA_W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      sgn_q <= 1'b0;
      div_q <= 1'b0;
    end else if (state_q == MD_IDLE && start_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      rem_q <= '0;
      quo_q <= abs_a;
      dvs_q <= abs_b;
      sgn_q <= signed_i;
      div_q <= div_i;
    end else if (state_q == MD_DIV) begin
      rem_q <= rem_nxt;
      quo_q <= {quo_q[DATA_W-2:0], sub_ok};
    end
  end

  assign a_neg = sgn_q & a_q[DATA_W-1];
  assign b_neg = sgn_q & b_q[DATA_W-1];
  assign ext_a = {{DATA_W{a_neg}}, a_q};
  assign ext_b = {{DATA_W{b_neg}}, b_q};
  assign prod  = ext_a * ext_b;

  always_comb begin
    hi_o = prod[2*DATA_W-1:DATA_W];
    lo_o = prod[DATA_W-1:0];
    if (div_q) begin
      if (b_q == '0) begin
        hi_o = a_q;
        lo_o = '1;
      end else begin
        hi_o = a_neg ? -rem_q : rem_q;
        lo_o = (a_neg ^ b_neg) ? -quo_q : quo_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/exe_stage_md.sv
//------------------------------------------------------------------------------
// exe_stage_md: execute stage (forwarding, ALU, HI/LO, mul/div, EX/MEM reg) | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module exe_stage_md
  import exe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5,
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op_in,
  input  logic [DATA_W-1:0] rs_in,
  input  logic [DATA_W-1:0] rt_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              imm_en,
  input  logic [4:0]        shamt_in,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [DATA_W-1:0] fwd_exe,
  input  logic [DATA_W-1:0] fwd_mem,
  input  logic [REG_AW-1:0] dest_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic [31:0]       pc_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              md_busy
);

  logic [DATA_W-1:0] opa, fwd_b, opb, alu_res, md_hi, md_lo;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              accept, no_wr, is_md, md_div, md_signed, md_start, md_done;

  logic              out_valid_q, out_reg_write_q, out_mem_read_q, out_mem_write_q, out_mem_to_reg_q;
  logic [DATA_W-1:0] out_result_q;
  logic [REG_AW-1:0] out_dest_q;
  logic [31:0]       out_pc_q;

  assign in_ready = !md_busy && !stall_in;
  assign accept   = in_valid && in_ready;

  always_comb begin
    case (fwd_a_sel)
      FWD_EXE: opa = fwd_exe;
      FWD_MEM: opa = fwd_mem;
      default: opa = rs_in;
    endcase
    case (fwd_b_sel)
      FWD_EXE: fwd_b = fwd_exe;
      FWD_MEM: fwd_b = fwd_mem;
      default: fwd_b = rt_in;
    endcase
  end

  assign opb = imm_en ? imm_in : fwd_b;

  always_comb begin
    alu_res   = '0;
    no_wr     = 1'b0;
    is_md     = 1'b0;
    md_div    = 1'b0;
    md_signed = 1'b0;
    case (op_in)
      OP_W'(OP_ADD):   alu_res = opa + opb;
      OP_W'(OP_SUB):   alu_res = opa - opb;
      OP_W'(OP_AND):   alu_res = opa & opb;
      OP_W'(OP_OR):    alu_res = opa | opb;
      OP_W'(OP_XOR):   alu_res = opa ^ opb;
      OP_W'(OP_NOR):   alu_res = ~(opa | opb);
      OP_W'(OP_SLT):   alu_res = {{(DATA_W-1){1'b0}}, $signed(opa) < $signed(opb)};
      OP_W'(OP_SLTU):  alu_res = {{(DATA_W-1){1'b0}}, opa < opb};
      OP_W'(OP_SLL):   alu_res = opb << shamt_in;
      OP_W'(OP_SRL):   alu_res = opb >> shamt_in;
      OP_W'(OP_SRA):   alu_res = $signed(opb) >>> shamt_in;
      OP_W'(OP_SLLV):  alu_res = opb << opa[4:0];
      OP_W'(OP_SRLV):  alu_res = opb >> opa[4:0];
      OP_W'(OP_SRAV):  alu_res = $signed(opb) >>> opa[4:0];
      OP_W'(OP_LUI):   alu_res = opb << 16;
      OP_W'(OP_MTHI),
      OP_W'(OP_MTLO):  no_wr = 1'b1;
      OP_W'(OP_MFHI):  alu_res = hi_q;
      OP_W'(OP_MFLO):  alu_res = lo_q;
      OP_W'(OP_MULT):  begin no_wr = 1'b1; is_md = 1'b1; md_signed = 1'b1; end
      OP_W'(OP_MULTU): begin no_wr = 1'b1; is_md = 1'b1; end
      OP_W'(OP_DIV):   begin no_wr = 1'b1; is_md = 1'b1; md_div = 1'b1; md_signed = 1'b1; end
      OP_W'(OP_DIVU):  begin no_wr = 1'b1; is_md = 1'b1; md_div = 1'b1; end
      default:         alu_res = '0;
    endcase
  end

  // A flushed instruction must leave no architectural side effect.
  assign md_start = accept && is_md && !flush;

  exe_muldiv #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_muldiv (
    .clk      (clk),
    .rstn     (rstn),
    .flush_i  (flush),
    .start_i  (md_start),
    .div_i    (md_div),
    .signed_i (md_signed),
    .a_i      (opa),
    .b_i      (opb),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .hi_o     (md_hi),
    .lo_o     (md_lo)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_done && !flush) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else if (accept && !flush) begin
      if (op_in == OP_W'(OP_MTHI)) hi_q <= opa;
      if (op_in == OP_W'(OP_MTLO)) lo_q <= opa;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_dest_q       <= '0;
      out_reg_write_q  <= 1'b0;
      out_mem_read_q   <= 1'b0;
      out_mem_write_q  <= 1'b0;
      out_mem_to_reg_q <= 1'b0;
      out_pc_q         <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (stall_in) begin
      out_valid_q <= out_valid_q;
    end else if (accept) begin
      out_valid_q      <= 1'b1;
      out_result_q     <= alu_res;
      out_dest_q       <= dest_in;
      out_reg_write_q  <= reg_write_in && !no_wr;
      out_mem_read_q   <= mem_read_in;
      out_mem_write_q  <= mem_write_in;
      out_mem_to_reg_q <= mem_to_reg_in;
      out_pc_q         <= pc_in;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_dest       = out_dest_q;
  assign out_reg_write  = out_reg_write_q;
  assign out_mem_read   = out_mem_read_q;
  assign out_mem_write  = out_mem_write_q;
  assign out_mem_to_reg = out_mem_to_reg_q;
  assign out_pc         = out_pc_q;
  assign hi_out         = hi_q;
  assign lo_out         = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_stage_md.sv
//------------------------------------------------------------------------------
// tb_exe_stage_md: directed self-checking bench for exe_stage_md | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_exe_stage_md;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, flush, stall_in, in_valid, in_ready;
  logic [4:0]  op_in, shamt_in, dest_in, out_dest;
  logic [31:0] rs_in, rt_in, imm_in, fwd_exe, fwd_mem, pc_in;
  logic        imm_en, reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, md_busy;
  logic [31:0] out_result, out_pc, hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage_md #(.DATA_W(32), .OP_W(5), .REG_AW(5), .MUL_LAT(4)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .stall_in(stall_in),
    .in_valid(in_valid), .in_ready(in_ready), .op_in(op_in),
    .rs_in(rs_in), .rt_in(rt_in), .imm_in(imm_in), .imm_en(imm_en),
    .shamt_in(shamt_in), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .fwd_exe(fwd_exe), .fwd_mem(fwd_mem), .dest_in(dest_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in), .pc_in(pc_in),
    .out_valid(out_valid), .out_result(out_result), .out_dest(out_dest),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .out_pc(out_pc), .hi_out(hi_out), .lo_out(lo_out), .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    op_in = op; rs_in = a; rt_in = b; in_valid = 1'b1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_md(input string tag, input int exp_cycles);
    int n = 0;
    while (md_busy && n < 200) begin
      step();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; stall_in = 1'b0; in_valid = 1'b0;
    op_in = OP_ADD; rs_in = '0; rt_in = '0; imm_in = '0; imm_en = 1'b0;
    shamt_in = '0; fwd_a_sel = FWD_RS; fwd_b_sel = FWD_RS; fwd_exe = '0; fwd_mem = '0;
    dest_in = 5'd3; reg_write_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0;
    mem_to_reg_in = 1'b0; pc_in = 32'h100;

    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_ready", in_ready, 1);
    step();
    rstn = 1'b1;
    step();

    // Forwarded ADD: 5 + 1
    fwd_a_sel = FWD_EXE; fwd_exe = 32'd5; mem_read_in = 1'b1;
    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 32'd6);
    chk("add_dest", out_dest, 5'd3);
    chk("add_regwr", out_reg_write, 1);
    chk("add_memrd", out_mem_read, 1);
    chk("add_pc", out_pc, 32'h100);
    fwd_a_sel = FWD_RS; mem_read_in = 1'b0;
    step();
    chk("bubble_valid", out_valid, 0);

    fwd_b_sel = FWD_MEM; fwd_mem = 32'd1;
    issue(OP_SUB, 32'd0, 32'd99);
    chk("sub_wrap", out_result, 32'hFFFF_FFFF);
    fwd_b_sel = FWD_RS;
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    chk("slt", out_result, 32'd1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    chk("sltu", out_result, 32'd0);
    shamt_in = 5'd4;
    issue(OP_SRA, 32'd0, 32'h8000_0000);
    chk("sra", out_result, 32'hF800_0000);
    issue(OP_SRLV, 32'd8, 32'h8000_0000);
    chk("srlv", out_result, 32'h0080_0000);
    imm_en = 1'b1; imm_in = 32'h1234;
    issue(OP_LUI, 32'd0, 32'd0);
    chk("lui", out_result, 32'h1234_0000);
    imm_en = 1'b0;

    issue(OP_MTHI, 32'hAAAA, 32'd0);
    chk("mthi_hi", hi_out, 32'hAAAA);
    chk("mthi_regwr", out_reg_write, 0);
    issue(OP_MFHI, 32'd0, 32'd0);
    chk("mfhi", out_result, 32'hAAAA);

    // MULT -3 * 7
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    chk("mult_busy", md_busy, 1);
    chk("mult_ready", in_ready, 0);
    chk("mult_regwr", out_reg_write, 0);
    repeat (4) step();
    chk("mult_hi_hold", hi_out, 32'hAAAA);
    wait_md("mult_lat", 1);
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFEB);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_md("multu_lat", 5);
    chk("multu_hi", hi_out, 32'd1);
    chk("multu_lo", lo_out, 32'hFFFF_FFFE);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_md("div_lat", 33);
    chk("div_lo", lo_out, 32'hFFFF_FFFD);
    chk("div_hi", hi_out, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_md("divmin_lat", 33);
    chk("divmin_lo", lo_out, 32'h8000_0000);
    chk("divmin_hi", hi_out, 32'd0);

    issue(OP_DIVU, 32'd9, 32'd0);
    wait_md("divu0_lat", 33);
    chk("divu0_lo", lo_out, 32'hFFFF_FFFF);
    chk("divu0_hi", hi_out, 32'd9);

    // Stall holds the SLL result
    shamt_in = 5'd4;
    issue(OP_SLL, 32'd0, 32'd1);
    chk("sll", out_result, 32'h10);
    stall_in = 1'b1;
    drive(OP_ADD, 32'd100, 32'd100);
    #1;
    chk("stall_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_result", out_result, 32'h10);
      chk("stall_valid", out_valid, 1);
    end
    flush = 1'b1;
    step();
    chk("flush_beats_stall", out_valid, 0);
    flush = 1'b0; stall_in = 1'b0; in_valid = 1'b0;
    step();

    // Flush an in-flight DIV
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (9) step();
    chk("flush_pre_busy", md_busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", md_busy, 0);
    chk("flush_valid", out_valid, 0);
    repeat (30) step();
    chk("flush_lo", lo_out, 32'hFFFF_FFFF);
    chk("flush_hi", hi_out, 32'd9);

    // Async reset mid-DIV
    pc_in = 32'h200;
    issue(OP_DIV, 32'd50, 32'd7);
    repeat (5) step();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_hi", hi_out, 0);
    chk("arst_lo", lo_out, 0);
    chk("arst_busy", md_busy, 0);
    step();
    rstn = 1'b1;
    step();
    issue(OP_MFLO, 32'd0, 32'd0);
    chk("arst_mflo_valid", out_valid, 1);
    chk("arst_mflo", out_result, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
